// File: rtl/latex_stream_pkg.sv
// Shared definitions for the LaTeX pair streamer.
// It holds the FSM state encoding, the character constants, the beacon
// string and the pacing helpers. It has no ports. It is imported by
// latex_pair_streamer and by lpsm_side_reader.
package latex_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_FETCH_L = 3'd2,
        S_FETCH_R = 3'd3,
        S_WAIT    = 3'd4,
        S_EMIT    = 3'd5,
        S_DONE    = 3'd6,
        S_BEACON  = 3'd7
    } state_e;

    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_PAD = 8'h20;

    localparam int BEACON_LEN = 13;
    localparam logic [8*BEACON_LEN-1:0] BEACON_STR = "CQ DE KC1GPW ";

    // Beat interval is 1 << (PACE_SHIFT * pace) cycles.
    localparam int PACE_SHIFT = 4;

    function automatic logic [15:0] pace_interval(input logic [1:0] p);
        return 16'd1 << (PACE_SHIFT * int'(p));
    endfunction

    // Character idx of the beacon. Index 0 is the leftmost character.
    function automatic logic [7:0] beacon_char(input int idx);
        logic [8*BEACON_LEN-1:0] t;
        t = BEACON_STR >> (8 * (BEACON_LEN - 1 - idx));
        return t[7:0];
    endfunction

endpackage

// File: rtl/lpsm_side_reader.sv
// Tracks one side (LHS or RHS) of a string pair.
// It holds the byte pointer, a one-word cache of the packed ROM word, the
// cache-valid bit and the ended flag. It also selects the current byte.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   load_i, base_i    load the word-aligned base pointer and restart the side
//   capture_i         latch mem_dout_i into the cache
//   mem_dout_i        ROM word; the high byte is the even character
//   advance_i         beat accepted; step the pointer, or mark the side ended
//   need_fetch_o      the cached word does not cover the current pointer
//   word_addr_o       ROM word address of the current pointer
//   char_o            character to emit (pad once ended)
//   ended_o           the side has ended, or the current byte is NUL
module lpsm_side_reader
    import latex_stream_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              capture_i,
    input  logic [15:0]       mem_dout_i,
    input  logic              advance_i,
    output logic              need_fetch_o,
    output logic [ADDR_W-1:0] word_addr_o,
    output logic [7:0]        char_o,
    output logic              ended_o
);

    logic [ADDR_W:0] ptr_q, ptr_d;
    logic [15:0]     word_q, word_d;
    logic            cache_vld_q, cache_vld_d;
    logic            ended_q, ended_d;
    logic [7:0]      sel_byte;

    assign sel_byte     = ptr_q[0] ? word_q[7:0] : word_q[15:8];
    assign ended_o      = ended_q | (sel_byte == CHAR_NUL);
    assign char_o       = ended_o ? CHAR_PAD : sel_byte;
    assign word_addr_o  = ptr_q[ADDR_W:1];
    // An odd pointer reuses the word fetched for its even partner.
    assign need_fetch_o = !ended_q && !(ptr_q[0] && cache_vld_q);

    always_comb begin
        ptr_d       = ptr_q;
        word_d      = word_q;
        cache_vld_d = cache_vld_q;
        ended_d     = ended_q;
        if (load_i) begin
            ptr_d       = {base_i, 1'b0};
            word_d      = 16'h0000;
            cache_vld_d = 1'b0;
            ended_d     = 1'b0;
        end else begin
            if (capture_i) begin
                word_d      = mem_dout_i;
                cache_vld_d = 1'b1;
            end
            if (advance_i) begin
                // A NUL freezes the pointer. From then on the side pads.
                if (ended_o) begin
                    ended_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            word_q      <= 16'h0000;
            cache_vld_q <= 1'b0;
            ended_q     <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            cache_vld_q <= cache_vld_d;
            ended_q     <= ended_d;
        end
    end

endmodule

// File: rtl/latex_pair_streamer.sv
// Streams function/transform character pairs from a packed-ASCII ROM.
// A rising edge on start begins a transfer. The two string pointers are
// looked up first. The single ROM port is then shared between the LHS and
// RHS strings. Each {lhs, rhs} beat goes out over valid/ready. Beacon mode
// streams a fixed call-sign string instead.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, line, mode,     transfer request; line, mode and pace are sampled
//   pace                   on the rising edge of start
//   ptr_line / ptr_addr    pointer mapper query, {lhs_base, rhs_base} response
//   mem_addr / mem_dout    ROM word port
//   lhs, rhs, valid, ready character pair output stream
//   busy, done, err        transfer status
//   dbg_state              current FSM state
// Handshake: a beat transfers on a clock edge where valid and ready are both
// high. While valid is high and ready is low, lhs and rhs do not change.
// valid stays high until the beat is accepted.
module latex_pair_streamer
    import latex_stream_pkg::*;
#(
    parameter int LINE_W    = 6,
    parameter int NUM_LINES = 51,
    parameter int ADDR_W    = 9,
    parameter int MAX_CHARS = 64,
    parameter int MEM_LAT   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LINE_W-1:0]   line,
    input  logic                mode,
    input  logic [1:0]          pace,
    output logic [LINE_W-1:0]   ptr_line,
    input  logic [2*ADDR_W-1:0] ptr_addr,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [15:0]         mem_dout,
    output logic [7:0]          lhs,
    output logic [7:0]          rhs,
    output logic                valid,
    input  logic                ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          dbg_state
);

    localparam int CNT_W = (MAX_CHARS > BEACON_LEN) ? $clog2(MAX_CHARS + 1)
                                                    : $clog2(BEACON_LEN + 1);

    state_e            state_q, state_d;
    logic              start_q;
    logic [LINE_W-1:0] line_q, line_d;
    logic              mode_q, mode_d;
    logic [1:0]        pace_q, pace_d;
    logic              err_q, err_d;
    logic [15:0]       pace_cnt_q, pace_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              lat_q, lat_d;

    logic              start_edge;
    logic              pace_met;
    logic              side_load, cap_l, cap_r, adv;
    logic              need_l, need_r, ended_l, ended_r;
    logic [ADDR_W-1:0] addr_l, addr_r;
    logic [7:0]        char_l, char_r;

    assign start_edge = start && !start_q;
    assign pace_met   = pace_cnt_q >= (pace_interval(pace_q) - 16'd1);

    lpsm_side_reader #(.ADDR_W(ADDR_W)) u_side_l (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (side_load),
        .base_i       (ptr_addr[2*ADDR_W-1:ADDR_W]),
        .capture_i    (cap_l),
        .mem_dout_i   (mem_dout),
        .advance_i    (adv),
        .need_fetch_o (need_l),
        .word_addr_o  (addr_l),
        .char_o       (char_l),
        .ended_o      (ended_l)
    );

    lpsm_side_reader #(.ADDR_W(ADDR_W)) u_side_r (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (side_load),
        .base_i       (ptr_addr[ADDR_W-1:0]),
        .capture_i    (cap_r),
        .mem_dout_i   (mem_dout),
        .advance_i    (adv),
        .need_fetch_o (need_r),
        .word_addr_o  (addr_r),
        .char_o       (char_r),
        .ended_o      (ended_r)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            line_q     <= '0;
            mode_q     <= 1'b0;
            pace_q     <= 2'd0;
            err_q      <= 1'b0;
            pace_cnt_q <= 16'd0;
            beat_cnt_q <= '0;
            lat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            line_q     <= line_d;
            mode_q     <= mode_d;
            pace_q     <= pace_d;
            err_q      <= err_d;
            pace_cnt_q <= pace_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            lat_q      <= lat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        mode_d     = mode_q;
        pace_d     = pace_q;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;
        lat_d      = 1'b0;
        side_load  = 1'b0;
        cap_l      = 1'b0;
        cap_r      = 1'b0;
        adv        = 1'b0;
        // The counter saturates, so a long ready stall never wraps it back
        // below the interval.
        pace_cnt_d = (pace_cnt_q == 16'hFFFF) ? pace_cnt_q : pace_cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    line_d     = line;
                    mode_d     = mode;
                    pace_d     = pace;
                    err_d      = 1'b0;
                    beat_cnt_d = '0;
                    pace_cnt_d = 16'd0;
                    if (mode) begin
                        state_d = S_BEACON;
                    end else if (32'(line) >= 32'(NUM_LINES)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                side_load  = 1'b1;
                pace_cnt_d = 16'd0;
                state_d    = S_FETCH_L;
            end
            S_FETCH_L: begin
                if (!need_l) begin
                    state_d = S_FETCH_R;
                end else if (MEM_LAT == 0 || lat_q) begin
                    cap_l   = 1'b1;
                    state_d = S_FETCH_R;
                end else begin
                    lat_d = 1'b1;
                end
            end
            S_FETCH_R: begin
                if (!need_r) begin
                    state_d = S_WAIT;
                end else if (MEM_LAT == 0 || lat_q) begin
                    cap_r   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    lat_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (pace_met) begin
                    state_d = (ended_l && ended_r) ? S_DONE : S_EMIT;
                end
            end
            S_BEACON: begin
                if (pace_met) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (ready) begin
                    pace_cnt_d = 16'd0;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (mode_q) begin
                        state_d = (beat_cnt_q == CNT_W'(BEACON_LEN - 1)) ? S_DONE : S_BEACON;
                    end else begin
                        adv = 1'b1;
                        if (beat_cnt_q == CNT_W'(MAX_CHARS - 1)) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH_L;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        valid     = (state_q == S_EMIT);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        err       = err_q;
        ptr_line  = line_q;
        dbg_state = state_q;
        lhs       = 8'h00;
        rhs       = 8'h00;
        mem_addr  = '0;
        if (valid) begin
            lhs = mode_q ? beacon_char(int'(beat_cnt_q)) : char_l;
            rhs = mode_q ? CHAR_PAD : char_r;
        end
        if (state_q == S_FETCH_L) begin
            mem_addr = addr_l;
        end else if (state_q == S_FETCH_R) begin
            mem_addr = addr_r;
        end
    end

endmodule
